// File: rtl/audio_i2c_responder.sv
// I2C write-only responder for the 3-byte codec frame {dev+W, reg[6:0]+d8, d[7:0]}.
// Define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-sample stability filter on SCL/SDA.
module audio_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_clk,
  inout  logic       i2c_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       soft_reset,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK0, ST_BYTE1, ST_ACK1,
    ST_BYTE2, ST_ACK2, ST_WAIT_STOP, ST_IGNORE
  } state_t;

  state_t      state_reg;
  logic [1:0]  line_in;
  logic [1:0]  line_sync;
  logic [1:0]  line_clean;
  logic        scl_prev_reg;
  logic        sda_prev_reg;
  logic        sda_oe_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [6:0]  reg_addr_reg;
  logic [8:0]  reg_data_reg;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det, in_frame;

  assign i2c_data = sda_oe_reg ? 1'b0 : 1'bz;
  assign line_in  = {i2c_data, i2c_clk};

  generate
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
      $error("audio_i2c_responder: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end
  endgenerate

  // Lines idle high, so every stage resets to 1 to avoid a false edge after reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= '1;
        else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in[gi]};
      end
      assign line_sync[gi] = sync_reg[SYNC_STAGES-1];
`ifdef I2C_GLITCH_FILTER_EN
      localparam int FCW = $clog2(FILTER_LEN + 1);
      logic [FCW-1:0] cnt_reg;
      logic           out_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
          out_reg <= 1'b1;
        end else if (line_sync[gi] == out_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
          out_reg <= line_sync[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign line_clean[gi] = out_reg;
`else
      assign line_clean[gi] = line_sync[gi];
`endif
    end
  endgenerate

  assign scl_s     = line_clean[0];
  assign sda_s     = line_clean[1];
  assign scl_rise  = scl_s & ~scl_prev_reg;
  assign scl_fall  = ~scl_s & scl_prev_reg;
  assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
  assign in_frame  = state_reg inside {ST_ADDR, ST_ACK0, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      sda_oe_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      reg_addr_reg <= '0;
      reg_data_reg <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      soft_reset   <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
      wr_valid     <= 1'b0;
      soft_reset   <= 1'b0;
      frame_err    <= 1'b0;
      // Bus conditions take priority over bit handling in every state.
      if (start_det) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= '0;
        busy        <= 1'b1;
        sda_oe_reg  <= 1'b0;
        frame_err   <= in_frame;
      end else if (stop_det) begin
        state_reg   <= ST_IDLE;
        busy        <= 1'b0;
        sda_oe_reg  <= 1'b0;
        frame_err   <= in_frame;
      end else begin
        case (state_reg)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (scl_rise && bit_cnt_reg != 4'd8) begin
              shift_reg   <= {shift_reg[6:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == 4'd8) begin
              bit_cnt_reg <= '0;
              sda_oe_reg  <= 1'b1;
              case (state_reg)
                ST_ADDR: begin
                  if (shift_reg == {DEV_ADDR, 1'b0}) begin
                    state_reg <= ST_ACK0;
                  end else begin
                    state_reg  <= ST_IGNORE;
                    sda_oe_reg <= 1'b0;
                  end
                end
                ST_BYTE1: begin
                  reg_addr_reg    <= shift_reg[7:1];
                  reg_data_reg[8] <= shift_reg[0];
                  state_reg       <= ST_ACK1;
                end
                default: begin
                  reg_data_reg[7:0] <= shift_reg;
                  state_reg         <= ST_ACK2;
                end
              endcase
            end
          end
          ST_ACK0, ST_ACK1, ST_ACK2: begin
            if (scl_fall) begin
              sda_oe_reg <= 1'b0;
              case (state_reg)
                ST_ACK0: state_reg <= ST_BYTE1;
                ST_ACK1: state_reg <= ST_BYTE2;
                default: begin
                  state_reg  <= ST_WAIT_STOP;
                  wr_valid   <= 1'b1;
                  wr_addr    <= reg_addr_reg;
                  wr_data    <= reg_data_reg;
                  soft_reset <= (reg_addr_reg == 7'd15);
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_i2c_responder.sv
// Self-checking bench for audio_i2c_responder: bit-banged I2C master plus a frame-level reference model.
module tb_audio_i2c_responder;
  localparam int Q = 8;  // clk cycles per quarter I2C bit

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_low = 1'b0;
  wire  sda_bus;
  logic       wr_valid, soft_reset, busy, frame_err;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;

  int total = 0;
  int bad = 0;
  int valid_cyc = 0, sr_cyc = 0, sr_with_valid = 0, ferr_cyc = 0, drive_cyc = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  audio_i2c_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2c_clk   (scl),
    .i2c_data  (sda_bus),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .soft_reset(soft_reset),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      valid_cyc <= valid_cyc + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (soft_reset === 1'b1) sr_cyc <= sr_cyc + 1;
    if (soft_reset === 1'b1 && wr_valid === 1'b1) sr_with_valid <= sr_with_valid + 1;
    if (frame_err === 1'b1) ferr_cyc <= ferr_cyc + 1;
    if (!sda_low && sda_bus === 1'b0) drive_cyc <= drive_cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master primitives (each leaves SCL low except stop).
  task automatic i2c_start();
    sda_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    sda_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_low = 1'b0; tick(Q + 4);
  endtask

  task automatic i2c_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_low = !b[i]; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
    end
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    i2c_bits(b);
    sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    ack = (sda_bus === 1'b0);
    tick(Q); scl = 1'b0; tick(Q);
  endtask

  // Frame-level model: only a write to device 0x1A is accepted; byte 1 is reg[6:0] and d8.
  function automatic void model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                output logic acc, output logic [6:0] a, output logic [8:0] d,
                                output logic sr);
    acc = (b0 == 8'h34);
    a   = b1 >> 1;
    d   = {b1[0], b2};
    sr  = acc && (a == 7'd15);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    total++;
    if ({wr_valid, soft_reset, busy, frame_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {wr_valid, soft_reset, busy, frame_err});
    end
    total++;
    if ({wr_addr, wr_data} !== 16'h0) begin
      bad++; $display("FAIL reset_regs: got addr=%h data=%h want 0/0", wr_addr, wr_data);
    end
    total++;
    if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
    reset_n = 1'b1; tick(6);
    total++;
    if ({wr_valid, busy, frame_err} !== 3'b000) begin
      bad++; $display("FAIL post_reset_idle: got %b want 000", {wr_valid, busy, frame_err});
    end
    $display("reset: outputs=%b sda=%b", {wr_valid, soft_reset, busy, frame_err}, sda_bus);
  endtask

  task automatic test_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int v0, s0, sv0, f0, d0;
    logic acc, exp_sr, a0, a1, a2, busy_mid;
    logic [6:0] exp_a;
    logic [8:0] exp_d;
    model(b0, b1, b2, acc, exp_a, exp_d, exp_sr);
    v0 = valid_cyc; s0 = sr_cyc; sv0 = sr_with_valid; f0 = ferr_cyc; d0 = drive_cyc;
    i2c_start();
    busy_mid = busy;
    i2c_byte(b0, a0); i2c_byte(b1, a1); i2c_byte(b2, a2);
    i2c_stop();
    $display("frame %h/%h/%h: acks=%b%b%b valid=%0d addr=%0d data=%h sr=%0d",
             b0, b1, b2, a0, a1, a2, valid_cyc - v0, last_addr, last_data, sr_cyc - s0);
    total++;
    if ({a0, a1, a2} !== {3{acc}}) begin
      bad++; $display("FAIL acks: got %b%b%b want %b", a0, a1, a2, {3{acc}});
    end
    total++;
    if (valid_cyc - v0 != (acc ? 1 : 0)) begin
      bad++; $display("FAIL wr_valid_cycles: got %0d want %0d", valid_cyc - v0, acc ? 1 : 0);
    end
    if (acc) begin
      total++;
      if (last_addr !== exp_a) begin bad++; $display("FAIL wr_addr: got %h want %h", last_addr, exp_a); end
      total++;
      if (last_data !== exp_d) begin bad++; $display("FAIL wr_data: got %h want %h", last_data, exp_d); end
    end else begin
      total++;
      if (drive_cyc != d0) begin bad++; $display("FAIL sda_driven: got %0d cycles want 0", drive_cyc - d0); end
    end
    total++;
    if (sr_cyc - s0 != (exp_sr ? 1 : 0)) begin
      bad++; $display("FAIL soft_reset_cycles: got %0d want %0d", sr_cyc - s0, exp_sr ? 1 : 0);
    end
    if (exp_sr) begin
      total++;
      if (sr_with_valid - sv0 != 1) begin
        bad++; $display("FAIL soft_reset_align: got %0d want 1", sr_with_valid - sv0);
      end
    end
    total++;
    if (ferr_cyc != f0) begin bad++; $display("FAIL frame_err_clean: got %0d want 0", ferr_cyc - f0); end
    total++;
    if (busy_mid !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy_mid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_write_directed();
    test_frame(8'h34, 8'h0E, 8'h42);
    test_frame(8'h34, 8'h05, 8'h79);
    test_frame(8'h34, 8'h1E, 8'h00);
  endtask

  task automatic test_reject();
    test_frame(8'h36, 8'h0E, 8'h42);
    test_frame(8'h35, 8'h0E, 8'h42);
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2;
    for (int i = 0; i < 8; i++) begin
      b0 = 8'h34;
      if ($urandom_range(0, 3) == 0) begin
        b0 = 8'($urandom);
        if (b0 == 8'h34) b0 = 8'h36;
      end
      b1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b1 = {7'd15, 1'($urandom)};
      b2 = 8'($urandom);
      test_frame(b0, b1, b2);
    end
  endtask

  task automatic test_repeated_start();
    int v0, f0;
    logic a0, a1, a2, a3, a4, acc, sr;
    logic [6:0] exp_a;
    logic [8:0] exp_d;
    model(8'h34, 8'h12, 8'h01, acc, exp_a, exp_d, sr);
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    i2c_byte(8'h34, a0); i2c_byte(8'h0E, a1);
    i2c_rstart();
    i2c_byte(8'h34, a2); i2c_byte(8'h12, a3); i2c_byte(8'h01, a4);
    i2c_stop();
    $display("rstart: ferr=%0d valid=%0d addr=%0d data=%h", ferr_cyc - f0, valid_cyc - v0, last_addr, last_data);
    total++;
    if ({a0, a1, a2, a3, a4} !== 5'b11111) begin bad++; $display("FAIL rstart_acks: got %b want 11111", {a0, a1, a2, a3, a4}); end
    total++;
    if (ferr_cyc - f0 != 1) begin bad++; $display("FAIL rstart_frame_err: got %0d want 1", ferr_cyc - f0); end
    total++;
    if (valid_cyc - v0 != 1) begin bad++; $display("FAIL rstart_valid: got %0d want 1", valid_cyc - v0); end
    total++;
    if (last_addr !== exp_a || last_data !== exp_d) begin
      bad++; $display("FAIL rstart_write: got %h/%h want %h/%h", last_addr, last_data, exp_a, exp_d);
    end
  endtask

  task automatic test_stop_abort();
    int v0, f0;
    logic a0, a1;
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    i2c_byte(8'h34, a0); i2c_byte(8'h0E, a1);
    i2c_stop();
    $display("abort: ferr=%0d valid=%0d busy=%b", ferr_cyc - f0, valid_cyc - v0, busy);
    total++;
    if (ferr_cyc - f0 != 1) begin bad++; $display("FAIL abort_frame_err: got %0d want 1", ferr_cyc - f0); end
    total++;
    if (valid_cyc - v0 != 0) begin bad++; $display("FAIL abort_valid: got %0d want 0", valid_cyc - v0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    logic a0, a1, a2, ax, b0k, b1k, b2k, acc, sr;
    logic [7:0] r1, r2;
    logic [6:0] exp_a;
    logic [8:0] exp_d;
    r1 = 8'($urandom); r2 = 8'($urandom);
    model(8'h34, r1, r2, acc, exp_a, exp_d, sr);
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    i2c_byte(8'h34, a0); i2c_byte(8'h0A, a1); i2c_byte(8'h55, a2);
    i2c_byte(8'hC3, ax);
    i2c_rstart();
    i2c_byte(8'h34, b0k); i2c_byte(r1, b1k); i2c_byte(r2, b2k);
    i2c_stop();
    $display("b2b: extra_ack=%b valid=%0d ferr=%0d addr=%0d data=%h", ax, valid_cyc - v0, ferr_cyc - f0, last_addr, last_data);
    total++;
    if (ax !== 1'b0) begin bad++; $display("FAIL b2b_extra_ack: got %b want 0", ax); end
    total++;
    if ({a0, a1, a2, b0k, b1k, b2k} !== 6'b111111) begin
      bad++; $display("FAIL b2b_acks: got %b want 111111", {a0, a1, a2, b0k, b1k, b2k});
    end
    total++;
    if (valid_cyc - v0 != 2) begin bad++; $display("FAIL b2b_valid: got %0d want 2", valid_cyc - v0); end
    total++;
    if (ferr_cyc - f0 != 0) begin bad++; $display("FAIL b2b_frame_err: got %0d want 0", ferr_cyc - f0); end
    total++;
    if (last_addr !== exp_a || last_data !== exp_d) begin
      bad++; $display("FAIL b2b_write: got %h/%h want %h/%h", last_addr, last_data, exp_a, exp_d);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic acking;
    i2c_start();
    i2c_bits(8'h34);
    sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    acking = (sda_bus === 1'b0);
    #3 reset_n = 1'b0;
    #1;
    $display("reset_mid_ack: acking=%b sda=%b busy=%b", acking, sda_bus, busy);
    total++;
    if (acking !== 1'b1) begin bad++; $display("FAIL mid_ack_driven: got %b want 1", acking); end
    total++;
    if (sda_bus !== 1'b1) begin bad++; $display("FAIL mid_ack_release: got %b want 1", sda_bus); end
    total++;
    if ({wr_valid, soft_reset, busy, frame_err} !== 4'b0000) begin
      bad++; $display("FAIL mid_ack_outputs: got %b want 0000", {wr_valid, soft_reset, busy, frame_err});
    end
    tick(Q); scl = 1'b0; tick(Q);
    reset_n = 1'b1; tick(Q);
    i2c_stop();
    test_frame(8'h34, 8'h0E, 8'h42);
  endtask

  initial begin
    test_reset();
    test_write_directed();
    test_reject();
    test_repeated_start();
    test_stop_abort();
    test_back_to_back();
    test_reset_mid_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
